// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared constants for the LED/GPIO PWM output engine.
//   N_CH_DEF / PWM_BITS_DEF / DIV_W_DEF : default parameter values
//   DUTY_FULL                           : all-ones duty (always on), slice to width
//   ch_w()                              : width of a channel index for n channels
package led_pwm_pkg;

  localparam int N_CH_DEF     = 8;
  localparam int PWM_BITS_DEF = 8;
  localparam int DIV_W_DEF    = 16;

  localparam logic [31:0] DUTY_FULL = 32'hFFFF_FFFF;

  // A single channel still needs a 1-bit index port.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_prescaler.sv
// led_pwm_prescaler: programmable divider producing a one-cycle clock enable.
//   clk       : board clock
//   resetn    : asynchronous active-low reset
//   div_ratio : terminal count; tick period is div_ratio+1 clk cycles
//   tick      : registered one-cycle enable, high the cycle after the wrap
module led_pwm_prescaler
  import led_pwm_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [DIV_W-1:0] div_ratio,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;

  // ">=" rather than "==" so that lowering div_ratio below the running count
  // wraps immediately instead of counting all the way through 2^DIV_W.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt >= div_ratio) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/led_pwm_bank.sv
// led_pwm_bank: PWM-gated LED drive plus heartbeat GPIO between SoC and pads.
//   clk          : board clock, all logic on the rising edge
//   resetn       : asynchronous active-low reset
//   div_ratio    : prescaler terminal count (tick period = div_ratio+1 clk)
//   led_in       : SoC LED on/off request per channel
//   duty_wr      : one-cycle strobe writing duty_val to channel duty_ch
//   duty_ch      : channel index for the duty write (out-of-range is ignored)
//   duty_val     : requested duty; 0 = always off, all-ones = always on
//   tick         : prescaler clock enable
//   led_out      : led_in gated by each channel's PWM, one clk latency
//   heartbeat    : toggles at every PWM period boundary
//   duty_pending : high while any staged duty awaits the period boundary
module led_pwm_bank
  import led_pwm_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int DIV_W    = DIV_W_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [DIV_W-1:0]         div_ratio,
  input  logic [N_CH-1:0]          led_in,
  input  logic                     duty_wr,
  input  logic [ch_w(N_CH)-1:0]    duty_ch,
  input  logic [PWM_BITS-1:0]      duty_val,
  output logic                     tick,
  output logic [N_CH-1:0]          led_out,
  output logic                     heartbeat,
  output logic                     duty_pending
);

  localparam int                  CH_W   = ch_w(N_CH);
  localparam logic [PWM_BITS-1:0] FULL_W = DUTY_FULL[PWM_BITS-1:0];

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                boundary;
  logic [N_CH-1:0]     on_vec;
  logic [N_CH-1:0]     pend_next;

  led_pwm_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk       (clk),
    .resetn    (resetn),
    .div_ratio (div_ratio),
    .tick      (tick)
  );

  assign boundary = tick && (pwm_cnt == FULL_W);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt   <= '0;
      heartbeat <= 1'b0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (boundary) heartbeat <= ~heartbeat;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [PWM_BITS-1:0] duty_stage;
    logic [PWM_BITS-1:0] duty_act;
    logic                pend;
    logic                wr_hit;

    // Indices >= N_CH match no channel, so such writes fall away here.
    assign wr_hit       = duty_wr && (duty_ch == CH_W'(i));
    // A write landing on a boundary re-arms pending for the next period,
    // while the boundary itself consumes the previously staged value.
    assign pend_next[i] = wr_hit || (pend && !boundary);
    assign on_vec[i]    = (pwm_cnt < duty_act) || (duty_act == FULL_W);

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        duty_stage <= FULL_W;
        duty_act   <= FULL_W;
        pend       <= 1'b0;
      end else begin
        if (wr_hit)           duty_stage <= duty_val;
        if (boundary && pend) duty_act   <= duty_stage;
        pend <= pend_next[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_out      <= '0;
      duty_pending <= 1'b0;
    end else begin
      led_out      <= led_in & on_vec;
      duty_pending <= |pend_next;
    end
  end

endmodule

// File: doc/led_pwm_bank.md
Name: led_pwm_bank

Overview:
Parametrised LED and GPIO output engine that sits between the SoC core and the board output pads.
- Prescaler: replaces a fixed free-running clock divider with a programmable one. It produces a single-cycle `tick` clock-enable for downstream logic, instead of a derived clock.
- PWM: per-channel brightness, applied to the SoC LED on/off bits.
- Heartbeat: a toggling GPIO that marks PWM-period wrap.
- All state is clocked on the single board clock.

Parameters:
- N_CH, 8, number of LED channels.
- PWM_BITS, 8, PWM counter and duty width.
- DIV_W, 16, prescaler ratio width.

Ports:
- clk  in  1  board clock, all logic rising-edge.
- resetn  in  1  asynchronous active-low reset.
- div_ratio  in  DIV_W  prescaler terminal count; tick period = div_ratio+1 clk cycles.
- led_in  in  N_CH  SoC LED on/off request per channel.
- duty_wr  in  1  one-cycle strobe, writes duty_val to the channel selected by duty_ch.
- duty_ch  in  $clog2(N_CH)  channel index for duty write.
- duty_val  in  PWM_BITS  requested duty.
- tick  out  1  one-cycle clock enable at prescaler wrap.
- led_out  out  N_CH  PWM-gated LED drive to pads.
- heartbeat  out  1  toggles once per PWM period.
- duty_pending  out  1  high while any staged duty write awaits the period boundary.

Behaviour:
- Reset (async assert, sync release) values:
  - div_cnt = 0, pwm_cnt = 0.
  - All duty_stage and duty_act = all-ones (full brightness), pending bits = 0.
  - tick = 0, led_out = 0, heartbeat = 0, duty_pending = 0.
- Prescaler:
  - div_cnt increments each clk.
  - When div_cnt >= div_ratio: div_cnt <= 0 and tick = 1 for that cycle (tick is registered, so asserted the following cycle).
  - div_ratio = 0 gives tick high every cycle.
  - div_ratio reduced below the current div_cnt mid-count: wrap on the next cycle with a tick. No counting through 2^DIV_W.
- PWM counter:
  - pwm_cnt advances only on tick.
  - Wraps from 2^PWM_BITS-1 to 0.
  - A wrap is a period boundary; it occurs on a tick cycle with pwm_cnt = max.
- Duty writes:
  - duty_wr loads duty_stage[duty_ch] and sets pending[duty_ch].
  - duty_ch >= N_CH: write ignored, no pending bit set.
  - At a period boundary, every pending channel copies duty_stage into duty_act and its pending bit clears.
  - Write coinciding with a boundary on the same channel: the new value goes to stage, pending stays set, and it applies at the next boundary. The old stage value is applied now.
  - Back-to-back writes to the same channel before a boundary: last write wins.
  - duty_pending = OR of pending bits (registered).
- Channel output:
  - led_out[i] <= led_in[i] & on_i, where on_i = (pwm_cnt < duty_act[i]) OR (duty_act[i] == all-ones).
  - duty 0 means always off; all-ones means always on (not max-1/2^N).
  - Latency is 1 clk from led_in or pwm_cnt change to led_out.
- Heartbeat: toggles on each period boundary. Its period is 2·(div_ratio+1)·2^PWM_BITS clk.
- Reset mid-operation: all counters, pending writes and duty values are discarded; the restart behaves identically to a cold reset.

Decomposition:
- Shared package `led_pwm_pkg`:
  - channel-index width function/localparam.
  - DUTY_FULL = all-ones constant.
  - Default parameter constants.
- One natural sub-module, `led_pwm_prescaler`: div_cnt and tick generation, instantiated once.
- Per-channel logic stays as a generate loop in the top.

Test Plan:
- Reset, then div_ratio = 3 → tick high every 4th clk; the first tick is 4 clk after resetn rises. After reset all led_in=1 → led_out all 1 (full duty).
- div_ratio = 0, duty ch2 = 64, led_in = 8'hFF → over one 256-cycle period, led_out[2] high exactly 64 clk. Channels still at full duty stay constant high.
- Write duty ch5 = 0 mid-period → duty_pending = 1; led_out[5] is unchanged until the boundary, then 0 for the whole next period; duty_pending drops.
- Write to duty_ch = N_CH (or out of range for a non-power-of-2 N_CH, e.g. 6 with N_CH=6) → no duty change, duty_pending stays 0.
- div_ratio changed 100 → 2 while div_cnt = 50 → tick on the next cycle, then every 3 clk. Heartbeat toggles every 3·256 clk.
- Assert resetn low mid-period with writes pending → all outputs 0 immediately (async); after release, duty is all-ones and duty_pending = 0.
